// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing the single-port word memory between instruction fetch
// and the data path; every access is a fixed IDLE -> ACCESS -> RESP transaction.
module mem_arbiter #(
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_ack,
   output logic [DATA_W-1:0] fetch_rdata,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [31:0]       data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_ack,
   output logic [DATA_W-1:0] data_rdata,
   output logic              fault,
   output logic              mem_load,
   output logic [31:0]       mem_address,
   output logic [DATA_W-1:0] mem_datain,
   input  logic [DATA_W-1:0] mem_dataout
);

   localparam int CNT_W_MIN = $clog2(STARVE_LIMIT + 1);
   localparam int CNT_W     = (CNT_W_MIN < 3) ? 3 : CNT_W_MIN;
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // An address is in range when no bit above the implemented word-address bits is set.
   function automatic logic addr_in_range(input logic [31:0] addr);
      return ((addr >> ADDR_W) == 32'd0);
   endfunction

   state_t             state_r;
   state_t             state_nxt_s;
   logic               win_data_r;
   logic               in_range_r;
   logic [CNT_W-1:0]   starve_cnt_r;
   logic               grant_fetch_s;
   logic               grant_data_s;
   logic               mem_load_nxt_s;
   logic               fetch_ack_nxt_s;
   logic               data_ack_nxt_s;
   logic               fault_nxt_s;
   logic [DATA_W-1:0]  rdata_cap_s;
   logic               fetch_ack_r;
   logic               data_ack_r;
   logic               fault_r;
   logic               mem_load_r;
   logic [31:0]        mem_address_r;
   logic [DATA_W-1:0]  mem_datain_r;
   logic [DATA_W-1:0]  fetch_rdata_r;
   logic [DATA_W-1:0]  data_rdata_r;

   // Data wins by default; fetch wins once it has lost STARVE_LIMIT grants in a row.
   always_comb begin
      grant_fetch_s = 1'b0;
      grant_data_s  = 1'b0;
      if (state_r == IDLE) begin
         grant_fetch_s = fetch_req & (~data_req | (starve_cnt_r == STARVE_MAX));
         grant_data_s  = data_req & ~grant_fetch_s;
      end else begin
         grant_fetch_s = 1'b0;
         grant_data_s  = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (fetch_req || data_req) begin
               state_nxt_s = ACCESS;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS:  state_nxt_s = RESP;
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Next values of the registered outputs; mem_load is set at the grant so it is high during ACCESS.
   always_comb begin
      mem_load_nxt_s  = 1'b0;
      fetch_ack_nxt_s = 1'b0;
      data_ack_nxt_s  = 1'b0;
      fault_nxt_s     = 1'b0;
      case (state_r)
         IDLE: begin
            mem_load_nxt_s = grant_data_s & data_we & addr_in_range(data_addr);
         end
         ACCESS: begin
            fetch_ack_nxt_s = ~win_data_r;
            data_ack_nxt_s  = win_data_r;
            fault_nxt_s     = ~in_range_r;
         end
         RESP: begin
            mem_load_nxt_s = 1'b0;
         end
         default: begin
            mem_load_nxt_s = 1'b0;
         end
      endcase
   end

   assign rdata_cap_s = in_range_r ? mem_dataout : {DATA_W{1'b0}};

   // Transaction latches, read-data capture and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_data_r    <= 1'b0;
         in_range_r    <= 1'b0;
         mem_address_r <= 32'd0;
         mem_datain_r  <= {DATA_W{1'b0}};
         fetch_rdata_r <= {DATA_W{1'b0}};
         data_rdata_r  <= {DATA_W{1'b0}};
         mem_load_r    <= 1'b0;
         fetch_ack_r   <= 1'b0;
         data_ack_r    <= 1'b0;
         fault_r       <= 1'b0;
      end else begin
         mem_load_r  <= mem_load_nxt_s;
         fetch_ack_r <= fetch_ack_nxt_s;
         data_ack_r  <= data_ack_nxt_s;
         fault_r     <= fault_nxt_s;
         case (state_r)
            IDLE: begin
               if (grant_fetch_s) begin
                  win_data_r    <= 1'b0;
                  in_range_r    <= addr_in_range(fetch_addr);
                  mem_address_r <= fetch_addr;
                  mem_datain_r  <= {DATA_W{1'b0}};
               end else if (grant_data_s) begin
                  win_data_r    <= 1'b1;
                  in_range_r    <= addr_in_range(data_addr);
                  mem_address_r <= data_addr;
                  mem_datain_r  <= data_wdata;
               end
            end
            // The write lands on this same edge, so a store captures the old word.
            ACCESS: begin
               if (win_data_r) begin
                  data_rdata_r <= rdata_cap_s;
               end else begin
                  fetch_rdata_r <= rdata_cap_s;
               end
            end
            default: begin
               win_data_r <= win_data_r;
            end
         endcase
      end
   end

   // Starvation counter: counts data grants that fetch lost, saturating at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == IDLE) begin
         if (grant_fetch_s || !fetch_req) begin
            starve_cnt_r <= {CNT_W{1'b0}};
         end else if (grant_data_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign fetch_ack   = fetch_ack_r;
   assign data_ack    = data_ack_r;
   assign fault       = fault_r;
   assign mem_load    = mem_load_r;
   assign mem_address = mem_address_r;
   assign mem_datain  = mem_datain_r;
   assign fetch_rdata = fetch_rdata_r;
   assign data_rdata  = data_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus hand-written
// contention, reset and late-arrival sequences, with a scoreboard checked on every ack.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack;
   logic [31:0] fetch_rdata;
   logic        data_req;
   logic        data_we;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_ack;
   logic [31:0] data_rdata;
   logic        fault;
   logic        mem_load;
   logic [31:0] mem_address;
   logic [31:0] mem_datain;
   logic [31:0] mem_dataout;

   mem_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_ack(data_ack), .data_rdata(data_rdata), .fault(fault),
      .mem_load(mem_load), .mem_address(mem_address), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
   );

   typedef struct {
      bit          is_data;
      logic [31:0] rdata;
      bit          fault;
   } exp_t;

   typedef struct {
      bit          is_data;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          exp_fault;
      int          exp_loads;
   } vec_t;

   logic [31:0] mem     [64];
   logic [31:0] ref_mem [64];
   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          load_cnt = 0;
   int          ack_total = 0;
   logic [31:0] last_fetch_exp = 32'd0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory model: combinational read, write on the clock edge while load is high.
   assign mem_dataout = mem[mem_address[5:0]];
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_00A5 + (32'(i) << 8);
      forever begin
         @(posedge clk);
         if (mem_load) mem[mem_address[5:0]] <= mem_datain;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every ack pops one expected record.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_load) load_cnt++;
         if (fetch_ack || data_ack) begin
            ack_total++;
            checks++;
            if (fetch_ack && data_ack) begin
               failures++;
               $display("FAIL ack_both: got both acks expected one");
            end else if (sb.size() == 0) begin
               failures++;
               $display("FAIL ack_unexpected: got ack data=%0d expected none", data_ack);
            end else begin
               e = sb.pop_front();
               if ((data_ack != e.is_data) || (fault != e.fault) ||
                   ((data_ack ? data_rdata : fetch_rdata) !== e.rdata)) begin
                  failures++;
                  $display("FAIL ack_record: got data=%0d rdata=%h fault=%0d expected data=%0d rdata=%h fault=%0d",
                           data_ack, data_ack ? data_rdata : fetch_rdata, fault, e.is_data, e.rdata, e.fault);
               end
            end
         end else if (fault) begin
            checks++;
            failures++;
            $display("FAIL fault_alone: got fault=1 expected 0 without ack");
         end
      end
   end

   task automatic wait_ack(input bit want_data, output int ack_cyc, output bit ok);
      ok = 1'b0;
      ack_cyc = 0;
      for (int n = 0; n < 12 && !ok; n++) begin
         @(negedge clk);
         if (want_data ? data_ack : fetch_ack) begin
            ok = 1'b1;
            ack_cyc = cyc;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout: got no ack expected one within 12 cycles (data=%0d)", want_data);
      end
   endtask

   task automatic push_exp(input bit is_data, input logic [31:0] addr, input bit flt);
      exp_t e;
      e.is_data = is_data;
      e.rdata   = (addr < 32'd64) ? ref_mem[addr[5:0]] : 32'd0;
      e.fault   = flt;
      sb.push_back(e);
      if (!is_data) last_fetch_exp = e.rdata;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_fetch_ack"}, 32'(fetch_ack), 32'd0);
      chk({tag, "_data_ack"}, 32'(data_ack), 32'd0);
      chk({tag, "_fault"}, 32'(fault), 32'd0);
      chk({tag, "_mem_load"}, 32'(mem_load), 32'd0);
      chk({tag, "_mem_address"}, mem_address, 32'd0);
      chk({tag, "_mem_datain"}, mem_datain, 32'd0);
      chk({tag, "_fetch_rdata"}, fetch_rdata, 32'd0);
      chk({tag, "_data_rdata"}, data_rdata, 32'd0);
   endtask

   // Called just after a rising edge; returns just after the edge that ends the ack cycle.
   task automatic run_txn(input vec_t v, output int ack_cyc);
      int start;
      bit ok;
      push_exp(v.is_data, v.addr, v.exp_fault);
      if (v.is_data && v.we && (v.addr < 32'd64)) ref_mem[v.addr[5:0]] = v.wdata;
      load_cnt = 0;
      data_we  = v.we;
      if (v.is_data) begin
         data_req   = 1'b1;
         data_addr  = v.addr;
         data_wdata = v.wdata;
      end else begin
         fetch_req  = 1'b1;
         fetch_addr = v.addr;
      end
      start = cyc;
      wait_ack(v.is_data, ack_cyc, ok);
      if (ok) chk("latency", 32'(ack_cyc - start), 32'd2);
      @(posedge clk);
      #1;
      fetch_req = 1'b0;
      data_req  = 1'b0;
      data_we   = 1'b0;
      chk("mem_load_cycles", 32'(load_cnt), 32'(v.exp_loads));
   endtask

   initial begin
      vec_t vecs[12];
      int   ack_c, prev_c, f_cyc, acks_before;
      bit   ok, mem_same;
      bit   pat_data [10];
      int   pat_cnt  [10];

      vecs[0]  = '{1'b1, 1'b1, 32'd4,          32'd44,          1'b0, 1};
      vecs[1]  = '{1'b1, 1'b0, 32'd4,          32'd0,           1'b0, 0};
      vecs[2]  = '{1'b0, 1'b0, 32'd0,          32'd0,           1'b0, 0};
      vecs[3]  = '{1'b0, 1'b0, 32'd1,          32'd0,           1'b0, 0};
      vecs[4]  = '{1'b0, 1'b0, 32'd2,          32'd0,           1'b0, 0};
      vecs[5]  = '{1'b1, 1'b1, 32'd64,         32'hDEAD_BEEF,   1'b1, 0};
      vecs[6]  = '{1'b1, 1'b1, 32'h8000_0000,  32'h1234_5678,   1'b1, 0};
      vecs[7]  = '{1'b0, 1'b0, 32'd100,        32'd0,           1'b1, 0};
      vecs[8]  = '{1'b1, 1'b0, 32'd63,         32'd0,           1'b0, 0};
      vecs[9]  = '{1'b0, 1'b1, 32'd5,          32'd0,           1'b0, 0};
      vecs[10] = '{1'b1, 1'b1, 32'd63,         32'hCAFE_F00D,   1'b0, 1};
      vecs[11] = '{1'b1, 1'b0, 32'd63,         32'd0,           1'b0, 0};

      for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_00A5 + (32'(i) << 8);

      rst_n = 1'b0;
      fetch_req = 1'b0; fetch_addr = 32'd0;
      data_req = 1'b0; data_we = 1'b0; data_addr = 32'd0; data_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #2;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      prev_c = 0;
      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i], ack_c);
         if (i > 0) chk("ack_spacing", 32'(ack_c - prev_c), 32'd3);
         prev_c = ack_c;
      end
      chk("fetch_rdata_held", fetch_rdata, last_fetch_exp);
      mem_same = 1'b1;
      for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) mem_same = 1'b0;
      chk("memory_contents", 32'(mem_same), 32'd1);

      // Contention: both requesters held high continuously.
      for (int k = 0; k < 10; k++) begin
         pat_data[k] = (k != 4) && (k != 9);
         pat_cnt[k]  = pat_data[k] ? ((k % 5) + 1) : 0;
         push_exp(pat_data[k], pat_data[k] ? 32'd10 : 32'd20, 1'b0);
      end
      load_cnt   = 0;
      fetch_req  = 1'b1; fetch_addr = 32'd20;
      data_req   = 1'b1; data_we = 1'b0; data_addr = 32'd10;
      for (int k = 0; k < 10; k++) begin
         ok = 1'b0;
         for (int n = 0; n < 12 && !ok; n++) begin
            @(negedge clk);
            ok = fetch_ack | data_ack;
         end
         if (!ok) begin
            checks++;
            failures++;
            $display("FAIL contention_timeout: got no ack expected grant %0d", k);
         end else begin
            chk("grant_order", 32'(data_ack), 32'(pat_data[k]));
            chk("starve_cnt", 32'(dut.starve_cnt_r), 32'(pat_cnt[k]));
         end
      end
      @(posedge clk);
      #1;
      fetch_req = 1'b0;
      data_req  = 1'b0;
      chk("contention_mem_load", 32'(load_cnt), 32'd0);

      // Reset during the ACCESS cycle of a store to addr 7.
      acks_before = ack_total;
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'd7; data_wdata = 32'h7777_7777;
      @(posedge clk);
      #1;
      chk("store_mem_load_access", 32'(mem_load), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      data_req = 1'b0; data_we = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("midreset_no_ack", 32'(ack_total), 32'(acks_before));
      chk("midreset_mem7", mem[7], ref_mem[7]);
      run_txn('{1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 0}, ack_c);

      // Late arrival: data request appears during the RESP cycle of a fetch.
      push_exp(1'b0, 32'd3, 1'b0);
      fetch_req = 1'b1; fetch_addr = 32'd3;
      wait_ack(1'b0, f_cyc, ok);
      push_exp(1'b1, 32'd9, 1'b0);
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'd9;
      @(posedge clk);
      #1;
      fetch_req = 1'b0;
      wait_ack(1'b1, ack_c, ok);
      if (ok) chk("late_arrival_spacing", 32'(ack_c - f_cyc), 32'd3);
      @(posedge clk);
      #1;
      data_req = 1'b0;
      repeat (4) @(posedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
